// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM state
// encoding and a constant-evaluable ceiling log2 used for counter sizing.
package wb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY  = 3'd1,
    RESP  = 3'd2,
    ERR   = 3'd3,
    FLUSH = 3'd4
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at
// or after ptr, wrapping modulo N, as a one-hot grant plus a valid flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  localparam logic [PTR_W:0] N_WIDE = (PTR_W + 1)'(N);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W:0]   wrap_s;
  logic [PTR_W-1:0] idx_s;

  // Walk the requests starting at ptr; the first hit wins, later ones are masked.
  always_comb begin
    gnt    = '0;
    valid  = 1'b0;
    sum_s  = '0;
    wrap_s = '0;
    idx_s  = '0;
    for (int off = 0; off < N; off++) begin
      sum_s      = {1'b0, ptr} + (PTR_W + 1)'(off);
      wrap_s     = (sum_s >= N_WIDE) ? (sum_s - N_WIDE) : sum_s;
      idx_s      = wrap_s[PTR_W-1:0];
      gnt[idx_s] = req[idx_s] & ~valid;
      valid      = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS
// classic masters. One single-beat transaction is in flight at a time; a
// watchdog turns a missing downstream ack into an error and then flushes any
// late response so the bridge never sees a duplicate strobe.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 1000
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic [7:0]                        timeout_cnt_o
);

  localparam int PTR_W = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);
  localparam int WD_W  = clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);

  arb_state_t             state_r;
  arb_state_t             state_s;
  logic [PTR_W-1:0]       ptr_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic                   we_r;
  logic [ADDR_WIDTH-1:0]  adr_r;
  logic [DATA_WIDTH-1:0]  wdat_r;
  logic [DATA_WIDTH-1:0]  rdat_r;
  logic [NUM_MASTERS-1:0] ack_r;
  logic [NUM_MASTERS-1:0] err_r;
  logic [WD_W-1:0]        wd_r;
  logic [7:0]             tocnt_r;

  logic [NUM_MASTERS-1:0] pick_gnt_s;
  logic                   pick_valid_s;
  logic [ADDR_WIDTH-1:0]  win_adr_s;
  logic [DATA_WIDTH-1:0]  win_dat_s;
  logic                   win_we_s;
  logic [PTR_W-1:0]       win_idx_s;
  logic                   wd_last_s;

  rr_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (m_stb_i),
    .ptr   (ptr_r),
    .gnt   (pick_gnt_s),
    .valid (pick_valid_s)
  );

  assign wd_last_s = (wd_r == WD_LAST);

  // AND-OR mux of the winning master's request fields and its index.
  always_comb begin
    win_adr_s = '0;
    win_dat_s = '0;
    win_we_s  = 1'b0;
    win_idx_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      win_adr_s = win_adr_s | ({ADDR_WIDTH{pick_gnt_s[i]}} & m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
      win_dat_s = win_dat_s | ({DATA_WIDTH{pick_gnt_s[i]}} & m_dat_i[i*DATA_WIDTH +: DATA_WIDTH]);
      win_we_s  = win_we_s | (pick_gnt_s[i] & m_we_i[i]);
      win_idx_s = win_idx_s | ({PTR_W{pick_gnt_s[i]}} & PTR_W'(i));
    end
  end

  // Next-state logic; ack takes priority over the final watchdog cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) state_s = BUSY;
        else              state_s = IDLE;
      end
      BUSY: begin
        if (s_ack_i)        state_s = RESP;
        else if (wd_last_s) state_s = ERR;
        else                state_s = BUSY;
      end
      RESP:  state_s = IDLE;
      ERR:   state_s = FLUSH;
      FLUSH: begin
        if (s_ack_i || wd_last_s) state_s = IDLE;
        else                      state_s = FLUSH;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_r <= IDLE;
    else            state_r <= state_s;
  end

  // Grant capture, watchdog, response pulses and timeout statistics.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ptr_r   <= '0;
      grant_r <= '0;
      we_r    <= 1'b0;
      adr_r   <= '0;
      wdat_r  <= '0;
      rdat_r  <= '0;
      ack_r   <= '0;
      err_r   <= '0;
      wd_r    <= '0;
      tocnt_r <= 8'd0;
    end else begin
      ack_r <= '0;
      err_r <= '0;
      case (state_r)
        IDLE: begin
          wd_r <= '0;
          if (pick_valid_s) begin
            grant_r <= pick_gnt_s;
            we_r    <= win_we_s;
            adr_r   <= win_adr_s;
            wdat_r  <= win_dat_s;
            ptr_r   <= (win_idx_s == PTR_LAST) ? '0 : (win_idx_s + PTR_W'(1));
          end
        end
        BUSY: begin
          if (s_ack_i) begin
            rdat_r <= s_dat_i;
            ack_r  <= grant_r;
            wd_r   <= '0;
          end else if (wd_last_s) begin
            rdat_r <= '0;
            err_r  <= grant_r;
            wd_r   <= '0;
            if (tocnt_r != 8'hFF) tocnt_r <= tocnt_r + 8'd1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        RESP: begin
          grant_r <= '0;
        end
        ERR: begin
          grant_r <= '0;
          wd_r    <= '0;
        end
        FLUSH: begin
          if (s_ack_i || wd_last_s) wd_r <= '0;
          else                      wd_r <= wd_r + WD_W'(1);
        end
        default: begin
          grant_r <= '0;
          wd_r    <= '0;
        end
      endcase
    end
  end

  // Strobe drops in the ack cycle so the bridge never sees it as a new request.
  assign s_stb_o       = (state_r == BUSY) & ~s_ack_i;
  assign s_we_o        = we_r;
  assign s_adr_o       = adr_r;
  assign s_dat_o       = wdat_r;
  assign m_dat_o       = rdat_r;
  assign m_ack_o       = ack_r;
  assign m_err_o       = err_r;
  assign grant_o       = grant_r;
  assign timeout_cnt_o = tocnt_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a cycle table for a write and a read,
// then hand-written sequences for round-robin order, watchdog timeout with
// flush, ack on the final watchdog cycle and reset during a transaction.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_stb;
  logic [NM-1:0]     m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack;
  logic [NM-1:0]     grant_o;
  logic [7:0]        tocnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS (NM),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_adr_i       (m_adr),
    .m_dat_i       (m_dat),
    .m_dat_o       (m_dat_o),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .s_stb_o       (s_stb_o),
    .s_we_o        (s_we_o),
    .s_adr_o       (s_adr_o),
    .s_dat_o       (s_dat_o),
    .s_dat_i       (s_dat),
    .s_ack_i       (s_ack),
    .grant_o       (grant_o),
    .timeout_cnt_o (tocnt_o)
  );

  typedef struct {
    logic [3:0]  stb;
    logic [3:0]  we;
    logic        ack;
    logic [31:0] sdat;
    logic        exp_stb;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_ack;
    logic        chk_bus;
    logic [31:0] exp_adr;
    logic [31:0] exp_wdat;
    logic        exp_we;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_stb"}, s_stb_o, 1'b0);
    chk({tag, "_grant"}, grant_o, 4'b0000);
    chk({tag, "_ack"}, m_ack_o, 4'b0000);
    chk({tag, "_err"}, m_err_o, 4'b0000);
    chk({tag, "_tocnt"}, tocnt_o, 8'd0);
    chk({tag, "_mdat"}, m_dat_o, 32'd0);
    chk({tag, "_sadr"}, s_adr_o, 32'd0);
  endtask

  initial begin
    int bad;
    int order [5];
    int seen;
    int waited;

    rst_n = 1'b0;
    m_stb = '0;
    m_we  = '0;
    m_adr = '0;
    m_dat = '0;
    s_dat = '0;
    s_ack = 1'b0;
    m_adr[0*AW +: AW] = 32'h0000_0100;
    m_dat[0*DW +: DW] = 32'h1111_1111;
    m_adr[1*AW +: AW] = 32'h0000_0200;
    m_dat[1*DW +: DW] = 32'h2222_2222;
    m_adr[2*AW +: AW] = 32'h0000_0040;
    m_dat[2*DW +: DW] = 32'hDEAD_BEEF;
    m_adr[3*AW +: AW] = 32'h0000_0300;
    m_dat[3*DW +: DW] = 32'h3333_3333;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Round-robin with all four masters requesting from reset
    order = '{0, 1, 2, 3, 0};
    m_stb = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      seen   = 0;
      waited = 0;
      while (!seen && waited < 10) begin
        step();
        s_ack = 1'b0;
        #1;
        waited++;
        if (s_stb_o) begin
          seen = 1;
          chk($sformatf("rr_grant_%0d", n), grant_o, 4'b0001 << order[n]);
          s_ack = 1'b1;
        end
      end
      if (!seen) begin
        errors++;
        $display("FAIL rr_wait_%0d: got no strobe within 10 cycles, required a grant", n);
      end
      step();
      s_ack = 1'b0;
      #1;
      chk($sformatf("rr_ack_%0d", n), m_ack_o, 4'b0001 << order[n]);
    end
    m_stb = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Cycle table: write from master 2 (ack 3 cycles after strobe), read from master 0
    vecs[0]  = '{4'b0100, 4'b0100, 1'b0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{4'b0100, 4'b0100, 1'b0, 32'h0,        1'b1, 4'b0100, 4'b0000, 1'b1, 32'h40,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{4'b0100, 4'b0100, 1'b0, 32'h0,        1'b1, 4'b0100, 4'b0000, 1'b1, 32'h40,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 32'h0,        1'b1, 4'b0100, 4'b0000, 1'b1, 32'h40,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{4'b0100, 4'b0100, 1'b1, 32'h0,        1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[5]  = '{4'b0100, 4'b0100, 1'b0, 32'h0,        1'b0, 4'b0100, 4'b0100, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[7]  = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b1, 4'b0001, 4'b0000, 1'b1, 32'h100, 32'h11111111, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{4'b0001, 4'b0000, 1'b1, 32'h12345678, 1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
    vecs[10] = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0001, 4'b0001, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h12345678};
    vecs[11] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};

    for (int v = 0; v < 12; v++) begin
      step();
      m_stb = vecs[v].stb;
      m_we  = vecs[v].we;
      s_ack = vecs[v].ack;
      s_dat = vecs[v].sdat;
      #1;
      chk($sformatf("vec%0d_s_stb", v), s_stb_o, vecs[v].exp_stb);
      chk($sformatf("vec%0d_grant", v), grant_o, vecs[v].exp_gnt);
      chk($sformatf("vec%0d_ack", v), m_ack_o, vecs[v].exp_ack);
      chk($sformatf("vec%0d_err", v), m_err_o, 4'b0000);
      if (vecs[v].chk_bus) begin
        chk($sformatf("vec%0d_s_adr", v), s_adr_o, vecs[v].exp_adr);
        chk($sformatf("vec%0d_s_dat", v), s_dat_o, vecs[v].exp_wdat);
        chk($sformatf("vec%0d_s_we", v), s_we_o, vecs[v].exp_we);
      end
      if (vecs[v].chk_rd) chk($sformatf("vec%0d_m_dat", v), m_dat_o, vecs[v].exp_rd);
    end

    // Watchdog timeout on master 1, late ack in FLUSH cycle 5
    step();
    m_stb = 4'b0010;
    m_we  = 4'b0010;
    s_ack = 1'b0;
    #1;
    chk("to_idle_grant", grant_o, 4'b0000);
    bad = 0;
    for (int k = 1; k <= TO; k++) begin
      step();
      #1;
      if (s_stb_o !== 1'b1 || m_err_o !== 4'b0000 || grant_o !== 4'b0010) bad++;
    end
    chk("to_busy_window_bad_cycles", bad, 0);
    step();
    #1;
    chk("to_err_pulse", m_err_o, 4'b0010);
    chk("to_count", tocnt_o, 8'd1);
    chk("to_mdat_zero", m_dat_o, 32'd0);
    chk("to_err_s_stb", s_stb_o, 1'b0);
    chk("to_err_ack", m_ack_o, 4'b0000);
    bad = 0;
    for (int f = 1; f <= 5; f++) begin
      step();
      m_stb = 4'b1000;
      m_we  = 4'b0000;
      s_ack = (f == 5);
      #1;
      if (grant_o !== 4'b0000 || s_stb_o !== 1'b0 || m_err_o !== 4'b0000) bad++;
    end
    chk("flush_no_grant_bad_cycles", bad, 0);
    step();
    s_ack = 1'b0;
    #1;
    chk("late_ack_discarded", m_ack_o, 4'b0000);
    chk("post_flush_idle_grant", grant_o, 4'b0000);
    step();
    #1;
    chk("post_flush_grant", grant_o, 4'b1000);
    chk("post_flush_s_stb", s_stb_o, 1'b1);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    m_stb = 4'b0000;
    #1;
    chk("post_flush_ack", m_ack_o, 4'b1000);

    // Ack coincident with the final watchdog cycle
    step();
    m_stb = 4'b0001;
    #1;
    bad = 0;
    for (int k = 1; k < TO; k++) begin
      step();
      #1;
      if (s_stb_o !== 1'b1) bad++;
    end
    chk("coinc_busy_bad_cycles", bad, 0);
    step();
    chk("coinc_last_s_stb", s_stb_o, 1'b1);
    s_ack = 1'b1;
    s_dat = 32'hCAFE_F00D;
    #1;
    chk("coinc_s_stb_drop", s_stb_o, 1'b0);
    step();
    s_ack = 1'b0;
    s_dat = 32'h0;
    #1;
    chk("coinc_ack", m_ack_o, 4'b0001);
    chk("coinc_no_err", m_err_o, 4'b0000);
    chk("coinc_tocnt", tocnt_o, 8'd1);
    chk("coinc_mdat", m_dat_o, 32'hCAFE_F00D);
    m_stb = 4'b0000;
    step();
    #1;
    chk("coinc_after_err", m_err_o, 4'b0000);

    // Reset asserted during BUSY (master 0 owns the bus, pointer now at 1)
    step();
    m_stb = 4'b0001;
    #1;
    step();
    #1;
    chk("pre_reset_busy", s_stb_o, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step();
    step();
    rst_n = 1'b1;
    s_ack = 1'b1;
    m_stb = 4'b0011;
    #1;
    chk("post_reset_idle", grant_o, 4'b0000);
    step();
    s_ack = 1'b0;
    #1;
    chk("post_reset_grant", grant_o, 4'b0001);
    chk("post_reset_no_ack", m_ack_o, 4'b0000);
    chk("post_reset_s_stb", s_stb_o, 1'b1);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    m_stb = 4'b0010;
    #1;
    chk("post_reset_ack", m_ack_o, 4'b0001);
    step();
    m_stb = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone slave port (the input of the wb_to_axi4_lite bridge) between NUM_MASTERS Wishbone classic masters.
- Grants one single-beat transaction at a time, forwards it downstream and routes the ack/data back to the granted master.
- A per-transaction watchdog returns an error to the master if the bridge does not respond. It recovers the bridge without issuing a duplicate transaction.

Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..8.
- DATA_WIDTH, 32: data bus width.
- ADDR_WIDTH, 32: address bus width.
- TIMEOUT, 1000: cycles from downstream strobe to required ack before error.

Ports:
- wb_clk_i  in  1  clock; all logic rising-edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- m_stb_i  in  NUM_MASTERS  per-master request strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i occupies slice i.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
- m_dat_o  out  DATA_WIDTH  shared read data, valid when that master's ack is high.
- m_ack_o  out  NUM_MASTERS  one-hot ack pulse.
- m_err_o  out  NUM_MASTERS  one-hot error pulse on timeout.
- s_stb_o  out  1  downstream strobe.
- s_we_o  out  1  downstream write enable.
- s_adr_o  out  ADDR_WIDTH  downstream address.
- s_dat_o  out  DATA_WIDTH  downstream write data.
- s_dat_i  in  DATA_WIDTH  downstream read data.
- s_ack_i  in  1  downstream ack, single-cycle pulse.
- grant_o  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- timeout_cnt_o  out  8  saturating count of timeouts since reset.

Behaviour:
- Reset (async assert, sync deassert in the system):
  - state=IDLE, all outputs 0.
  - RR pointer = master 0 has highest priority.
- States: IDLE, BUSY, RESP, ERR, FLUSH.
- IDLE: if any m_stb_i is set, select the first requester at or after the RR pointer (wrapping modulo NUM_MASTERS). Then:
  - Register grant, we, adr and dat from that slice; go to BUSY.
  - Set the RR pointer to winner+1 (wrap to 0 after NUM_MASTERS-1).
  - Single request: 1 cycle from m_stb_i sampled to s_stb_o high.
- BUSY:
  - s_stb_o = busy_q AND NOT s_ack_i (combinational drop). The bridge must never see strobe in the cycle it returns to idle, so no duplicate transaction occurs.
  - Watchdog counts cycles in BUSY.
  - On s_ack_i: latch s_dat_i into m_dat_o; go to RESP. Counter clears.
  - On watchdog reaching TIMEOUT-1 with no ack: go to ERR.
  - Ack and timeout in the same cycle: ack wins.
- RESP: m_ack_o[grant]=1 for exactly 1 cycle; grant_o clears; go to IDLE. Total master-visible latency = downstream latency + 2 cycles.
- ERR:
  - m_err_o[grant]=1 for 1 cycle; m_dat_o = 0; s_stb_o already low.
  - timeout_cnt_o increments, saturating at 255.
  - Go to FLUSH.
- FLUSH:
  - Wait for a late s_ack_i (discarded), or a further TIMEOUT cycles, then go to IDLE.
  - No new grant is issued while in FLUSH.
- A master that drops m_stb_i while granted does not abort the transaction. The ack is still pulsed and may be ignored.
- s_ack_i outside BUSY/FLUSH is ignored.
- m_stb_i from non-granted masters is ignored until IDLE. Masters are expected to hold strobe until ack/err.
- Reset mid-transaction: everything returns to reset values immediately; a pending downstream response is ignored after reset.
- Watchdog width = clog2(TIMEOUT+1).

Decomposition:
- Shared package wb_arb_pkg: state encoding localparams (IDLE, BUSY, RESP, ERR, FLUSH) and the clog2 function.
- Sub-module rr_pick: combinational round-robin selector with inputs req[N] and ptr, outputs one-hot gnt and valid. Reusable by other arbiters in the codebase.

Test Plan:
- Single write, master 2: adr=0x40, dat=0xDEADBEEF, downstream ack 3 cycles after s_stb_o.
  -> s_adr_o=0x40, s_dat_o=0xDEADBEEF, s_we_o=1; m_ack_o=0b0100 exactly once; s_stb_o low in the ack cycle.
- Read, master 0: s_dat_i=0x12345678 on ack.
  -> m_dat_o=0x12345678 while m_ack_o[0]=1; one downstream strobe only.
- Masters 0-3 all request continuously from reset.
  -> grant order 0,1,2,3,0; no master granted twice before all others are served.
- Master 1 requests, no downstream ack for 1000 cycles.
  -> m_err_o[1] pulse at BUSY cycle 1000+1; timeout_cnt_o=1; no grant until FLUSH ends; late ack at FLUSH cycle 5 is discarded, then IDLE.
- wb_rst_ni low during BUSY.
  -> all outputs 0 asynchronously; after release, first request goes to master 0 priority.
- Ack coincident with the final watchdog cycle.
  -> m_ack_o pulses, no m_err_o, timeout_cnt_o unchanged.
